// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the SRL-backed start/token FIFO.
// Holds the head-register state enum and the occupancy-counter width derivation.
package fifo_pkg;

  typedef enum logic {
    IDLE_EMPTY = 1'b0,
    HEAD_VALID = 1'b1
  } head_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter must represent 0..depth inclusive, and never collapse to zero bits.
  function automatic int cnt_width(input int depth);
    int w;
    w = clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/srl_start_fifo_storage.sv
// Write-enabled shift register: index 0 holds the newest word, read is combinational at addr.
// Latency: write visible after the enabling edge; no backpressure (caller gates we).
module srl_start_fifo_storage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = (int'(addr) < DEPTH) ? sr[addr] : '0;

endmodule

// File: rtl/srl_start_fifo_reader.sv
// FWFT consumer-side controller over SRL storage: occupancy, read address and head register.
// Capacity DEPTH+1; push-to-head latency 2 edges on an empty FIFO; 1 word/cycle when streaming.
module srl_start_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] srl_dout;
  logic                  push;
  logic                  pop;
  logic                  load;
  head_state_e           state;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;
  assign load = (cnt != '0) & (~if_empty_n | pop);
  assign addr = (cnt == '0) ? '0 : ADDR_WIDTH'(cnt - CW'(1));

  // Push and load together: the old head is read before the shift, so cnt holds.
  always_comb begin
    cnt_next = cnt;
    if (push & ~load)      cnt_next = cnt + CW'(1);
    else if (load & ~push) cnt_next = cnt - CW'(1);
  end

  srl_start_fifo_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_storage (
    .clk (clk),
    .we  (push),
    .addr(addr),
    .din (if_din),
    .dout(srl_dout)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      if_full_n <= 1'b1;
      if_dout   <= '0;
      state     <= IDLE_EMPTY;
    end else begin
      cnt       <= cnt_next;
      if_full_n <= (cnt_next < CW'(DEPTH));
      case (state)
        IDLE_EMPTY: begin
          if (load) begin
            if_dout <= srl_dout;
            state   <= HEAD_VALID;
          end
        end
        HEAD_VALID: begin
          if (load)     if_dout <= srl_dout;
          else if (pop) state   <= IDLE_EMPTY;
        end
        default: state <= IDLE_EMPTY;
      endcase
    end
  end

  assign if_empty_n = (state == HEAD_VALID);

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n) cnt <= CW'(DEPTH));
  a_addr_bound: assert property (@(posedge clk) disable iff (!reset_n) int'(addr) < DEPTH);

endmodule

// File: tb/tb_srl_start_fifo_reader.sv
// Bench for srl_start_fifo_reader: directed vector table, streaming sequence, randomized run vs a queue model.
module tb_srl_start_fifo_reader;

  localparam int DW = 8;
  localparam int AW = 1;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_write_ce = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read_ce = 1'b0;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  srl_start_fifo_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_write_ce(if_write_ce),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_read_ce (if_read_ce),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n)
  );

  // Reference model: SRL contents as a queue (front = oldest) plus the head register.
  logic [DW-1:0] m_srl[$];
  bit            m_vld = 1'b0;
  logic [DW-1:0] m_dout = '0;
  bit            m_full_n = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge: update the model from the current inputs, then compare after the edge.
  task automatic cycle();
    bit p, q, l;
    if (!reset_n) begin
      m_srl.delete();
      m_vld    = 1'b0;
      m_dout   = '0;
      m_full_n = 1'b1;
    end else begin
      p = if_write && if_write_ce && m_full_n;
      q = if_read && if_read_ce && m_vld;
      l = (m_srl.size() != 0) && (!m_vld || q);
      if (l) begin
        m_dout = m_srl.pop_front();
        m_vld  = 1'b1;
      end else if (q) begin
        m_vld = 1'b0;
      end
      if (p) m_srl.push_back(if_din);
      m_full_n = (m_srl.size() < DP);
    end
    @(posedge clk);
    #1;
    chk("model_full_n", 32'(if_full_n), 32'(m_full_n));
    chk("model_empty_n", 32'(if_empty_n), 32'(m_vld));
    chk("model_dout", 32'(if_dout), 32'(m_dout));
  endtask

  typedef struct packed {
    logic          rst_n;
    logic          wce;
    logic          wr;
    logic [DW-1:0] din;
    logic          rce;
    logic          rd;
    logic          full_n;
    logic          empty_n;
    logic [DW-1:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic wce, input logic wr, input logic [DW-1:0] din,
                              input logic rce, input logic rd, input logic f, input logic e,
                              input logic [DW-1:0] d);
    vec_t v;
    v = '{rst, wce, wr, din, rce, rd, f, e, d};
    return v;
  endfunction

  vec_t vecs[32];
  logic [DW-1:0] got[$];

  initial begin
    int sent;

    // reset, single token, fill/overflow/drain, read_ce stall, write_ce gate, mid-op reset
    vecs[0]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    vecs[1]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    vecs[2]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    vecs[3]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    vecs[4]  = mk(1, 1, 1, 8'h01, 0, 0, 1, 0, 8'h00);
    vecs[5]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h01);
    vecs[6]  = mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h01);
    vecs[7]  = mk(1, 1, 1, 8'hA1, 0, 0, 1, 0, 8'h01);
    vecs[8]  = mk(1, 1, 1, 8'hB2, 0, 0, 1, 1, 8'hA1);
    vecs[9]  = mk(1, 1, 1, 8'hC3, 0, 0, 0, 1, 8'hA1);
    vecs[10] = mk(1, 1, 1, 8'hD4, 0, 0, 0, 1, 8'hA1);
    vecs[11] = mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hB2);
    vecs[12] = mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hC3);
    vecs[13] = mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'hC3);
    vecs[14] = mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'hC3);
    vecs[15] = mk(1, 1, 1, 8'h5E, 0, 0, 1, 0, 8'hC3);
    vecs[16] = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h5E);
    for (int i = 17; i <= 20; i++) vecs[i] = mk(1, 0, 0, 8'h00, 0, 1, 1, 1, 8'h5E);
    vecs[21] = mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h5E);
    vecs[22] = mk(1, 0, 1, 8'h77, 0, 0, 1, 0, 8'h5E);
    vecs[23] = mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h5E);
    vecs[24] = mk(1, 1, 1, 8'h11, 0, 0, 1, 0, 8'h5E);
    vecs[25] = mk(1, 1, 1, 8'h22, 0, 0, 1, 1, 8'h11);
    vecs[26] = mk(1, 1, 1, 8'h33, 0, 0, 0, 1, 8'h11);
    vecs[27] = mk(0, 1, 1, 8'h99, 1, 1, 1, 0, 8'h00);
    vecs[28] = mk(1, 1, 1, 8'h44, 0, 0, 1, 0, 8'h00);
    vecs[29] = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h44);
    vecs[30] = mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h44);
    vecs[31] = mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h44);

    #1;
    for (int i = 0; i < 32; i++) begin
      reset_n     = vecs[i].rst_n;
      if_write_ce = vecs[i].wce;
      if_write    = vecs[i].wr;
      if_din      = vecs[i].din;
      if_read_ce  = vecs[i].rce;
      if_read     = vecs[i].rd;
      cycle();
      chk($sformatf("vec%0d_full_n", i), 32'(if_full_n), 32'(vecs[i].full_n));
      chk($sformatf("vec%0d_empty_n", i), 32'(if_empty_n), 32'(vecs[i].empty_n));
      chk($sformatf("vec%0d_dout", i), 32'(if_dout), 32'(vecs[i].dout));
    end

    // Streaming: push 1..16 while reading every cycle.
    sent = 0;
    got.delete();
    reset_n     = 1'b1;
    if_write_ce = 1'b1;
    if_read_ce  = 1'b1;
    if_read     = 1'b1;
    for (int c = 0; c < 40 && got.size() < 16; c++) begin
      if (sent < 16) begin
        if_write = 1'b1;
        if_din   = 8'(sent + 1);
      end else begin
        if_write = 1'b0;
        if_din   = '0;
      end
      if (if_empty_n && if_read) got.push_back(if_dout);
      if (if_write && if_full_n) sent++;
      cycle();
      chk("stream_full_n", 32'(if_full_n), 32'd1);
    end
    chk("stream_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size(); i++) chk($sformatf("stream_word%0d", i), 32'(got[i]), 32'(i + 1));

    // Randomized traffic with occasional resets, checked against the model each cycle.
    for (int c = 0; c < 1500; c++) begin
      reset_n     = ($urandom_range(0, 63) != 0);
      if_write_ce = ($urandom_range(0, 7) != 0);
      if_write    = $urandom_range(0, 1) == 1;
      if_din      = 8'($urandom);
      if_read_ce  = ($urandom_range(0, 7) != 0);
      if_read     = $urandom_range(0, 2) != 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
